ds_adc_decim: RTL and testbench

Synthesizable multi-channel first-order delta-sigma ADC digital core. Per channel it samples the asynchronous analogue comparator output, registers the 1-bit decision that drives the external RC integrator, and counts ones over a runtime-programmable oversampling window (sinc1 accumulate-and-dump). Completed conversions are streamed channel by channel over a valid/ready interface toward the acquisition logic.

---
 rtl/ds_adc_pkg.sv | 13 +
 rtl/ds_adc_chan.sv | 36 +++
 rtl/ds_adc_decim.sv | 119 +++++++++++
 tb/tb_ds_adc_decim.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_adc_pkg.sv
// Shared types and constants for the delta-sigma ADC decimator.
package ds_adc_pkg;

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   localparam int C_OSR_MIN = 2;

   // Keeps index widths at least one bit for single-channel builds.
   function automatic int safeClog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ds_adc_chan.sv
// One modulator channel: comparator synchronizer, decision flop, sinc1
// accumulator and the hold register that freezes a finished window.
module ds_adc_chan #(
   parameter int C_OSR_BITS    = 8,
   parameter int C_SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  comp,
   input  logic                  run,
   input  logic                  winEnd,
   input  logic                  capture,
   output logic                  drv,
   output logic [C_OSR_BITS-1:0] hold
);

   logic [C_SYNC_STAGES-1:0] syncQ;
   logic [C_OSR_BITS-1:0]    acc;

   assign drv = syncQ[C_SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rstb) begin
         syncQ <= '0;
         acc   <= '0;
         hold  <= '0;
      end else begin
         // Shift form works for any depth, including a single stage.
         syncQ <= (syncQ << 1) | C_SYNC_STAGES'(comp);
         if (!run || winEnd) acc <= '0;
         else                acc <= acc + C_OSR_BITS'(drv);
         if (capture) hold <= acc + C_OSR_BITS'(drv);
      end
   end

endmodule

// File: rtl/ds_adc_decim.sv
// Multi-channel first-order delta-sigma core: shared window timing, frame
// capture and a valid/ready streamer that emits one result per channel.
module ds_adc_decim
   import ds_adc_pkg::*;
#(
   parameter  int C_CHANNELS    = 2,
   parameter  int C_OSR_BITS    = 8,
   parameter  int C_SYNC_STAGES = 2,
   localparam int C_CH_BITS     = safeClog2(C_CHANNELS)
) (
   input  logic                  CLK,
   input  logic                  RSTB,
   input  logic                  EN,
   input  logic [C_OSR_BITS-1:0] OSR,
   input  logic [C_CHANNELS-1:0] COMP,
   output logic [C_CHANNELS-1:0] DRV,
   output logic [C_OSR_BITS-1:0] DATA,
   output logic [C_CH_BITS-1:0]  CH,
   output logic                  LAST,
   output logic                  VALID,
   input  logic                  READY,
   output logic                  OVERRUN
);

   logic [C_CHANNELS-1:0][C_OSR_BITS-1:0] hold;
   logic [C_OSR_BITS-1:0] cnt, lenQ, osrClamp, winLen;
   logic                  active, winEnd, accept, xfer, lastCh;
   logic                  overrunQ, overrunNxt;
   logic [C_CH_BITS-1:0]  chQ, chNxt;
   state_t                state, stateNxt;

   assign osrClamp = (OSR < C_OSR_BITS'(C_OSR_MIN)) ? C_OSR_BITS'(C_OSR_MIN) : OSR;
   // The first enabled cycle already counts, so it must see the live OSR.
   assign winLen   = active ? lenQ : osrClamp;
   assign winEnd   = EN && (cnt == winLen - C_OSR_BITS'(1));

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         active <= 1'b0;
         cnt    <= '0;
         lenQ   <= '0;
      end else if (!EN) begin
         active <= 1'b0;
         cnt    <= '0;
      end else begin
         active <= 1'b1;
         if (!active || winEnd) lenQ <= osrClamp;
         cnt <= winEnd ? '0 : cnt + C_OSR_BITS'(1);
      end
   end

   for (genvar c = 0; c < C_CHANNELS; c++) begin : gChan
      ds_adc_chan #(
         .C_OSR_BITS   (C_OSR_BITS),
         .C_SYNC_STAGES(C_SYNC_STAGES)
      ) uChan (
         .clk    (CLK),
         .rstb   (RSTB),
         .comp   (COMP[c]),
         .run    (EN),
         .winEnd (winEnd),
         .capture(accept),
         .drv    (DRV[c]),
         .hold   (hold[c])
      );
   end

   assign xfer   = (state == S_STREAM) && READY;
   assign lastCh = (chQ == C_CH_BITS'(C_CHANNELS - 1));

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         state    <= S_IDLE;
         chQ      <= '0;
         overrunQ <= 1'b0;
      end else begin
         state    <= stateNxt;
         chQ      <= chNxt;
         overrunQ <= overrunNxt;
      end
   end

   always_comb begin
      stateNxt   = state;
      chNxt      = chQ;
      overrunNxt = overrunQ;
      accept     = 1'b0;
      case (state)
         S_IDLE: begin
            if (winEnd) begin
               accept   = 1'b1;
               stateNxt = S_STREAM;
               chNxt    = '0;
            end
         end
         S_STREAM: begin
            if (xfer) begin
               if (lastCh) begin
                  chNxt = '0;
                  if (winEnd) accept   = 1'b1;
                  else        stateNxt = S_IDLE;
               end else begin
                  chNxt = chQ + C_CH_BITS'(1);
               end
            end
            // A window ending mid-stream has nowhere to go.
            if (winEnd && !(xfer && lastCh)) overrunNxt = 1'b1;
         end
         default: stateNxt = S_IDLE;
      endcase
   end

   assign VALID   = (state == S_STREAM);
   assign CH      = chQ;
   assign LAST    = VALID && lastCh;
   assign DATA    = hold[chQ];
   assign OVERRUN = overrunQ;

endmodule

// File: tb/tb_ds_adc_decim.sv
// Scoreboard bench for ds_adc_decim: expected frames are queued as stimulus
// is applied and popped by a monitor on every VALID/READY transfer.
module tb_ds_adc_decim;

   localparam int NCH = 2;
   localparam int OB  = 8;
   localparam int CHB = 1;

   logic           CLK = 1'b0;
   logic           RSTB, EN, READY;
   logic [OB-1:0]  OSR;
   logic [NCH-1:0] COMP, DRV;
   logic [OB-1:0]  DATA;
   logic [CHB-1:0] CH;
   logic           LAST, VALID, OVERRUN;

   ds_adc_decim #(.C_CHANNELS(NCH), .C_OSR_BITS(OB), .C_SYNC_STAGES(2)) dut (
      .CLK(CLK), .RSTB(RSTB), .EN(EN), .OSR(OSR), .COMP(COMP), .DRV(DRV),
      .DATA(DATA), .CH(CH), .LAST(LAST), .VALID(VALID), .READY(READY),
      .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   typedef struct {int ch; int data; bit last;} item_t;

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   bit    monEn = 1'b0;
   item_t expQ[$];
   int    x0Cyc[$];

   always @(posedge CLK) cyc <= cyc + 1;

   // Transfer happens on the next rising edge; record that edge's index.
   always @(negedge CLK) begin : mon
      item_t e;
      if (monEn && VALID && READY) begin
         total++;
         if (expQ.size() == 0) begin
            bad++;
            $display("FAIL unexpected_xfer: got ch=%0d data=%0d last=%0d, none expected", CH, DATA, LAST);
         end else begin
            e = expQ.pop_front();
            if (CH !== CHB'(e.ch) || DATA !== OB'(e.data) || LAST !== e.last) begin
               bad++;
               $display("FAIL xfer: got ch=%0d data=%0d last=%0d, expected ch=%0d data=%0d last=%0d",
                        CH, DATA, LAST, e.ch, e.data, e.last);
            end
         end
         if (CH == 0) x0Cyc.push_back(cyc + 1);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic pushFrame(input int d0, input int d1);
      expQ.push_back('{ch: 0, data: d0, last: 1'b0});
      expQ.push_back('{ch: 1, data: d1, last: 1'b1});
   endtask

   task automatic waitDrain(input int budget, input string name);
      int g = 0;
      while (expQ.size() > 0 && g < budget) begin
         tick(1);
         g++;
      end
      READY = 1'b0;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout: %0d items left, expected 0", name, expQ.size());
      end
   endtask

   task automatic drain();
      EN    = 1'b0;
      READY = 1'b1;
      monEn = 1'b0;
      tick(10);
      expQ.delete();
      x0Cyc.delete();
      monEn = 1'b1;
   endtask

   task automatic test_reset();
      RSTB = 1'b0; EN = 1'b0; READY = 1'b1; OSR = 8'd16; COMP = 2'b11;
      tick(4);
      total++;
      if ({DRV, DATA, CH, LAST, VALID, OVERRUN} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got drv=%b data=%0d ch=%0d last=%b valid=%b ovr=%b, expected all 0",
                  DRV, DATA, CH, LAST, VALID, OVERRUN);
      end
      RSTB = 1'b1;
      tick(1);
      total++;
      if (DRV !== 2'b00) begin bad++; $display("FAIL drv_lat1: got %b expected 00", DRV); end
      tick(1);
      total++;
      if (DRV !== 2'b11) begin bad++; $display("FAIL drv_lat2: got %b expected 11", DRV); end
      for (int i = 0; i < 10; i++) begin
         tick(1);
         total++;
         if (VALID !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b expected 0", VALID); end
      end
      monEn = 1'b1;
   endtask

   task automatic test_dc();
      int t0;
      COMP = 2'b01; OSR = 8'd16; READY = 1'b1;
      tick(3);
      repeat (3) pushFrame(16, 0);
      x0Cyc.delete();
      EN = 1'b1; t0 = cyc;
      waitDrain(100, "dc");
      for (int k = 0; k < 3; k++) begin
         total++;
         if (x0Cyc.size() <= k || x0Cyc[k] != t0 + 17 + 16 * k) begin
            bad++;
            $display("FAIL dc_timing[%0d]: got edge %0d expected %0d", k,
                     (x0Cyc.size() > k) ? x0Cyc[k] - t0 : -1, 17 + 16 * k);
         end
      end
      total++;
      if (OVERRUN !== 1'b0) begin bad++; $display("FAIL dc_overrun: got %b expected 0", OVERRUN); end
      drain();
   endtask

   task automatic test_half();
      int g = 0;
      COMP = 2'b00; OSR = 8'd16; READY = 1'b1;
      repeat (4) begin tick(1); COMP[0] = ~COMP[0]; end
      repeat (3) pushFrame(8, 0);
      EN = 1'b1;
      while (expQ.size() > 0 && g < 100) begin
         tick(1);
         COMP[0] = ~COMP[0];
         g++;
      end
      READY = 1'b0;
      total++;
      if (expQ.size() != 0) begin bad++; $display("FAIL half_timeout: %0d items left, expected 0", expQ.size()); end
      COMP = 2'b01;
      drain();
   endtask

   task automatic test_backpressure();
      int t0;
      COMP = 2'b01; OSR = 8'd16; READY = 1'b0;
      tick(3);
      repeat (2) pushFrame(16, 0);
      EN = 1'b1; t0 = cyc;
      for (int i = 1; i <= 40; i++) begin
         tick(1);
         if (i >= 16) begin
            total++;
            if (VALID !== 1'b1 || CH !== 1'b0 || DATA !== 8'd16) begin
               bad++;
               $display("FAIL bp_hold@%0d: got valid=%b ch=%0d data=%0d expected 1/0/16", i, VALID, CH, DATA);
            end
         end
         total++;
         if (OVERRUN !== 1'(i >= 32)) begin
            bad++;
            $display("FAIL bp_overrun@%0d: got %b expected %b", i, OVERRUN, i >= 32);
         end
      end
      READY = 1'b1;
      waitDrain(60, "bp");
      total++;
      if (x0Cyc.size() != 2 || x0Cyc[0] != t0 + 41 || x0Cyc[1] != t0 + 49) begin
         bad++;
         $display("FAIL bp_timing: got %0d xfers first=%0d second=%0d expected 41/49", x0Cyc.size(),
                  (x0Cyc.size() > 0) ? x0Cyc[0] - t0 : -1, (x0Cyc.size() > 1) ? x0Cyc[1] - t0 : -1);
      end
      drain();
      RSTB = 1'b0;
      tick(2);
      RSTB = 1'b1;
      total++;
      if (OVERRUN !== 1'b0) begin bad++; $display("FAIL bp_ovr_clear: got %b expected 0", OVERRUN); end
      tick(3);
   endtask

   task automatic test_osr_change();
      int t0;
      int expEdge[3] = '{17, 49, 81};
      COMP = 2'b01; OSR = 8'd16; READY = 1'b1;
      pushFrame(16, 0); pushFrame(32, 0); pushFrame(32, 0);
      EN = 1'b1; t0 = cyc;
      tick(5);
      OSR = 8'd32;
      waitDrain(150, "osr");
      for (int k = 0; k < 3; k++) begin
         total++;
         if (x0Cyc.size() <= k || x0Cyc[k] != t0 + expEdge[k]) begin
            bad++;
            $display("FAIL osr_timing[%0d]: got edge %0d expected %0d", k,
                     (x0Cyc.size() > k) ? x0Cyc[k] - t0 : -1, expEdge[k]);
         end
      end
      OSR = 8'd16;
      drain();
   endtask

   task automatic test_clamp_en();
      int t0;
      COMP = 2'b01; OSR = 8'd0; READY = 1'b1;
      repeat (5) pushFrame(2, 0);
      EN = 1'b1; t0 = cyc;
      waitDrain(40, "clamp");
      for (int k = 0; k < 5; k++) begin
         total++;
         if (x0Cyc.size() <= k || x0Cyc[k] != t0 + 3 + 2 * k) begin
            bad++;
            $display("FAIL clamp_timing[%0d]: got edge %0d expected %0d", k,
                     (x0Cyc.size() > k) ? x0Cyc[k] - t0 : -1, 3 + 2 * k);
         end
      end
      total++;
      if (OVERRUN !== 1'b0) begin bad++; $display("FAIL b2b_overrun: got %b expected 0", OVERRUN); end
      drain();
      OSR = 8'd16; READY = 1'b1;
      pushFrame(16, 0);
      EN = 1'b1;
      tick(7);
      EN = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         total++;
         if (VALID !== 1'b0) begin bad++; $display("FAIL en_abort_valid: got %b expected 0", VALID); end
      end
      EN = 1'b1; t0 = cyc;
      waitDrain(40, "en_restart");
      total++;
      if (x0Cyc.size() != 1 || x0Cyc[0] != t0 + 17) begin
         bad++;
         $display("FAIL en_restart_timing: got %0d xfers at edge %0d expected 1 at 17", x0Cyc.size(),
                  (x0Cyc.size() > 0) ? x0Cyc[0] - t0 : -1);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int g = 0;
      COMP = 2'b01; OSR = 8'd16; READY = 1'b0;
      expQ.push_back('{ch: 0, data: 16, last: 1'b0});
      EN = 1'b1;
      while (VALID !== 1'b1 && g < 40) begin tick(1); g++; end
      total++;
      if (VALID !== 1'b1) begin bad++; $display("FAIL rm_wait: got valid=%b expected 1", VALID); end
      READY = 1'b1;
      tick(1);
      READY = 1'b0;
      total++;
      if (VALID !== 1'b1 || CH !== 1'b1 || LAST !== 1'b1) begin
         bad++;
         $display("FAIL rm_pending: got valid=%b ch=%0d last=%b expected 1/1/1", VALID, CH, LAST);
      end
      RSTB = 1'b0; EN = 1'b0;
      tick(1);
      total++;
      if (VALID !== 1'b0 || CH !== 1'b0) begin
         bad++;
         $display("FAIL rm_abort: got valid=%b ch=%0d expected 0/0", VALID, CH);
      end
      RSTB = 1'b1; READY = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         total++;
         if (VALID !== 1'b0) begin bad++; $display("FAIL rm_quiet: got valid=%b expected 0", VALID); end
      end
      total++;
      if (expQ.size() != 0) begin bad++; $display("FAIL rm_scoreboard: %0d items left expected 0", expQ.size()); end
   endtask

   initial begin
      test_reset();
      test_dc();
      test_half();
      test_backpressure();
      test_osr_change();
      test_clamp_en();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
